// File: rtl/div_32.sv
// rtl/div_32.sv - 32-bit signed non-restoring divider, 33-cycle latency
// Optional zero-divisor bypass and flag: define DIV_ZERO_DETECT_EN.

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  // Per-group generate/propagate lookahead, group carry passed to the next group
  always_comb begin
    logic       cb;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    cb    = i_cin;
    g     = '0;
    p     = '0;
    c     = '0;
    o_sum = '0;
    for (int k = 0; k < 8; k++) begin
      g    = i_a[4*k +: 4] & i_b[4*k +: 4];
      p    = i_a[4*k +: 4] ^ i_b[4*k +: 4];
      c[0] = cb;
      c[1] = g[0] | (p[0] & cb);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cb);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cb);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cb);
      o_sum[4*k +: 4] = p ^ c[3:0];
      cb = c[4];
    end
    o_cout = cb;
  end

endmodule

module div_32 (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [32:0] r_a;
  logic [31:0] r_q;
  logic [31:0] r_m;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic        r_dz;

  logic        w_accept;
  logic        w_div_is_zero;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_a_sh;
  logic [32:0] w_add_a;
  logic [32:0] w_add_b;
  logic        w_cin;
  logic [31:0] w_sum_lo;
  logic        w_cout;
  logic        w_sum_hi;
  logic [32:0] w_sum;
  logic [31:0] w_rem_mag;

`ifdef DIV_ZERO_DETECT_EN
  assign w_div_is_zero = (divisor == 32'd0);
`else
  assign w_div_is_zero = 1'b0;
`endif

  // A request is taken while idle or on the edge that ends the done cycle
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Magnitudes are unsigned, so 0x80000000 maps to 2^31 unchanged
  assign w_dvd_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign w_dvs_mag = divisor[31]  ? (~divisor  + 32'd1) : divisor;

  assign w_a_sh    = {r_a[31:0], r_q[31]};

  // Adder operand select: iterate (shifted A +/- M) or final correction (A + M)
  always_comb begin
    w_add_a = w_a_sh;
    w_add_b = {1'b0, r_m};
    w_cin   = 1'b0;
    if (r_state == S_FIX) begin
      w_add_a = r_a;
    end else if (!r_a[32]) begin
      w_add_b = ~{1'b0, r_m};
      w_cin   = 1'b1;
    end
  end

  cla_32 u_cla (
    .i_a    (w_add_a[31:0]),
    .i_b    (w_add_b[31:0]),
    .i_cin  (w_cin),
    .o_sum  (w_sum_lo),
    .o_cout (w_cout)
  );

  assign w_sum_hi  = w_add_a[32] ^ w_add_b[32] ^ w_cout;
  assign w_sum     = {w_sum_hi, w_sum_lo};
  assign w_rem_mag = r_a[32] ? w_sum_lo : r_a[31:0];

  // State register
  always_ff @(posedge clock) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and status decode
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_div_is_zero ? S_FIX : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == 6'd31) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_accept) w_next = w_div_is_zero ? S_FIX : S_ITER;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift/add-subtract iterations, sign fix-up
  always_ff @(posedge clock) begin
    if (clear) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= '0;
      r_cnt   <= '0;
      r_m     <= w_dvs_mag;
      r_neg_q <= dividend[31] ^ divisor[31];
      r_neg_r <= dividend[31];
      r_zero  <= w_div_is_zero;
      // On the zero bypass Q carries the raw dividend straight to the remainder
      r_q     <= w_div_is_zero ? dividend : w_dvd_mag;
    end else if (r_state == S_ITER) begin
      r_a   <= w_sum;
      r_q   <= {r_q[30:0], ~w_sum[32]};
      r_cnt <= r_cnt + 6'd1;
    end else if (r_state == S_FIX) begin
      if (r_zero) begin
        r_quot <= 32'hFFFF_FFFF;
        r_rem  <= r_q;
        r_dz   <= 1'b1;
      end else begin
        r_quot <= r_neg_q ? (~r_q + 32'd1) : r_q;
        r_rem  <= r_neg_r ? (~w_rem_mag + 32'd1) : w_rem_mag;
        r_dz   <= 1'b0;
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

endmodule
